// File: rtl/nco_core.sv
// nco_core: phase accumulator driving a quarter-wave sine ROM, quadrature out (I = cos, Q = sin).
// Latency: I/Q follow phase_acc by 3 clocks; free-running, one sample per clock, no backpressure.
// Build option NCO_PHASE_DITHER_EN: LFSR dither added below the ROM address bits before lookup.
module nco_core #(
    parameter int PHASE_ACC_BITS = 20,
    parameter int LUT_DATA_BITS  = 13,
    parameter int LUT_ADDR_BITS  = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic        [PHASE_ACC_BITS-1:0] phase_inc,
    output logic        [PHASE_ACC_BITS-1:0] phase_acc,
    output logic signed [LUT_DATA_BITS-1:0]  I,
    output logic signed [LUT_DATA_BITS-1:0]  Q
);
    localparam int  P       = PHASE_ACC_BITS;
    localparam int  D       = LUT_DATA_BITS;
    localparam int  A       = LUT_ADDR_BITS;
    localparam int  MW      = D - 1;
    localparam int  TRUNC   = P - 2 - A;
    localparam int  N       = 1 << A;
    localparam int  MAG_MAX = (1 << MW) - 1;
    localparam real PI      = 3.14159265358979323846;

    // Half-LSB offset samples each bin centre, so the ROM never holds 0 or needs a +M+1 entry.
    function automatic logic [MW-1:0] rom_entry(input int k);
        real x;
        x = real'(MAG_MAX) * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(N));
        return MW'($rtoi(x + 0.5));
    endfunction

    logic [MW-1:0] rom [N];
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [MW-1:0] ENTRY = rom_entry(k);
        assign rom[k] = ENTRY;
    end

    logic [P-1:0] acc_q, acc_d;
    logic [P-1:0] phase_eff;

    assign acc_d = acc_q + phase_inc;

`ifdef NCO_PHASE_DITHER_EN
    localparam int DW = (TRUNC > 16) ? 16 : TRUNC;
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end

    if (DW > 0) begin : g_dither
        assign phase_eff = acc_q + P'(lfsr_q[DW-1:0]);
    end else begin : g_no_dither
        assign phase_eff = acc_q;
    end
`else
    assign phase_eff = acc_q;
`endif

    if (TRUNC > 0) begin : g_trunc
        logic unused_trunc_bits;
        assign unused_trunc_bits = ^phase_eff[TRUNC-1:0];
    end

    logic [1:0]   quad;
    logic [A-1:0] addr;
    assign quad = phase_eff[P-1 -: 2];
    assign addr = phase_eff[P-3 -: A];

    // Stage 1: quadrant plus mirrored addresses; odd quadrants run the ROM backwards for sine.
    logic         vld1_q;
    logic [1:0]   quad1_q;
    logic [A-1:0] sin_addr1_q, cos_addr1_q;

    // Stage 2: ROM magnitudes
    logic          vld2_q;
    logic [1:0]    quad2_q;
    logic [MW-1:0] sin_mag2_q, cos_mag2_q;

    // Stage 3: signed outputs; invalid stage-2 data forces 0 while the pipe refills after reset.
    logic signed [D-1:0] sin_q, cos_q;
    logic        [D-1:0] sin_ext, cos_ext, sin_d, cos_d;

    always_comb begin
        sin_ext = {1'b0, sin_mag2_q};
        cos_ext = {1'b0, cos_mag2_q};
        sin_d   = '0;
        cos_d   = '0;
        if (vld2_q) begin
            sin_d = quad2_q[1] ? -sin_ext : sin_ext;
            cos_d = (quad2_q[1] ^ quad2_q[0]) ? -cos_ext : cos_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            vld1_q      <= 1'b0;
            quad1_q     <= '0;
            sin_addr1_q <= '0;
            cos_addr1_q <= '0;
            vld2_q      <= 1'b0;
            quad2_q     <= '0;
            sin_mag2_q  <= '0;
            cos_mag2_q  <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            vld1_q      <= 1'b1;
            quad1_q     <= quad;
            sin_addr1_q <= quad[0] ? ~addr : addr;
            cos_addr1_q <= quad[0] ? addr : ~addr;
            vld2_q      <= vld1_q;
            quad2_q     <= quad1_q;
            sin_mag2_q  <= rom[sin_addr1_q];
            cos_mag2_q  <= rom[cos_addr1_q];
            sin_q       <= signed'(sin_d);
            cos_q       <= signed'(cos_d);
        end
    end

    assign phase_acc = acc_q;
    assign I         = cos_q;
    assign Q         = sin_q;
endmodule

// File: tb/tb_nco_core.sv
// Bench for nco_core: reference model evaluates ideal sin/cos at each phase bin centre.
module tb_nco_core;
    localparam int  P    = 20;
    localparam int  D    = 13;
    localparam int  A    = 10;
    localparam int  M    = 4095;
    localparam int  MASK = (1 << P) - 1;
    localparam real PI   = 3.14159265358979323846;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [P-1:0]        phase_inc = '0;
    logic [P-1:0]        phase_acc;
    logic signed [D-1:0] I, Q;

    int          tests = 0;
    int          fails = 0;
    int unsigned m_acc = 0;
    int unsigned hist[$];
    int          q_tab[4];
    int          i_tab[4];

    nco_core #(.PHASE_ACC_BITS(P), .LUT_DATA_BITS(D), .LUT_ADDR_BITS(A)) dut (
        .clk       (clk),
        .rst       (rst),
        .phase_inc (phase_inc),
        .phase_acc (phase_acc),
        .I         (I),
        .Q         (Q)
    );

    always #5 clk = ~clk;

    // Ideal oscillator: sample at the centre of the 2^(A+2)-bin phase cell, round magnitude.
    function automatic int ideal(input int unsigned acc, input bit want_cos);
        int unsigned idx;
        real theta, v, mag;
        int r;
        idx   = acc >> (P - 2 - A);
        theta = 2.0 * PI * (real'(idx) + 0.5) / real'(1 << (A + 2));
        v     = want_cos ? $cos(theta) : $sin(theta);
        mag   = (v < 0.0) ? -v : v;
        r     = $rtoi(real'(M) * mag + 0.5);
        return (v < 0.0) ? -r : r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One clock: advance the model at the edge, compare everything on the falling edge.
    task automatic tick(input string tag);
        int e_i, e_q;
        @(posedge clk);
        if (rst) begin
            m_acc = (m_acc + phase_inc) & MASK;
            hist.push_back(m_acc);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        @(negedge clk);
        e_i = 0;
        e_q = 0;
        if (hist.size() == 4) begin
            e_i = ideal(hist[0], 1'b1);
            e_q = ideal(hist[0], 1'b0);
        end
        chk({tag, ".acc"}, int'(phase_acc), int'(m_acc));
        chk({tag, ".I"}, int'(I), e_i);
        chk({tag, ".Q"}, int'(Q), e_q);
    endtask

    // Called just after a falling edge: reset lands mid low-phase, checked before the next edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, ".rst_acc"}, int'(phase_acc), 0);
        chk({tag, ".rst_I"}, int'(I), 0);
        chk({tag, ".rst_Q"}, int'(Q), 0);
        m_acc = 0;
        hist.delete();
        hist.push_back(0);
    endtask

    task automatic quad_seq(input string tag);
        phase_inc = 20'd262144;
        rst       = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick(tag);
            chk({tag, ".seq_acc"}, int'(phase_acc), (k * 262144) & MASK);
            if (k >= 3) begin
                chk({tag, ".seq_Q"}, int'(Q), q_tab[(k - 3) % 4]);
                chk({tag, ".seq_I"}, int'(I), i_tab[(k - 3) % 4]);
            end else begin
                chk({tag, ".seq_Q0"}, int'(Q), 0);
                chk({tag, ".seq_I0"}, int'(I), 0);
            end
        end
    endtask

    initial begin
        int xings, worst_pw, max_mag, prev_q, bad_steps, pw, len, hold_i, hold_q;
        q_tab[0] = 3;    q_tab[1] = 4095; q_tab[2] = -3;    q_tab[3] = -4095;
        i_tab[0] = 4095; i_tab[1] = -3;   i_tab[2] = -4095; i_tab[3] = 3;

        // Reset held for 50 clocks, then count by 5
        #2 rst = 1'b0;
        #1;
        chk("s1.rst_acc", int'(phase_acc), 0);
        chk("s1.rst_I", int'(I), 0);
        chk("s1.rst_Q", int'(Q), 0);
        hist.push_back(0);
        for (int k = 0; k < 50; k++) tick("s1.hold");
        phase_inc = 20'd5;
        rst       = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick("s1.run");
            chk("s1.count5", int'(phase_acc), 5 * k);
        end

        // Zero increment freezes the phase at 0
        async_reset("s2");
        phase_inc = '0;
        rst       = 1'b1;
        for (int k = 0; k < 3; k++) tick("s2");
        chk("s2.I", int'(I), 4095);
        chk("s2.Q", int'(Q), 3);
        hold_i = int'(I);
        hold_q = int'(Q);
        for (int k = 0; k < 10; k++) tick("s2.hold");
        chk("s2.I_held", int'(I), hold_i);
        chk("s2.Q_held", int'(Q), hold_q);

        // Quarter-turn steps
        async_reset("s3");
        quad_seq("s3");

        // Nyquist: quadrant 0 <-> 2
        async_reset("nyq");
        phase_inc = 20'd524288;
        rst       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick("nyq");
            if (k >= 3) chk("nyq.Q", int'(Q), (k % 2 == 1) ? 3 : -3);
        end

        // Descending wrap
        async_reset("s5");
        phase_inc = 20'hFFFFF;
        rst       = 1'b1;
        prev_q    = 0;
        bad_steps = 0;
        for (int k = 1; k <= 700; k++) begin
            tick("s5");
            if (k <= 2) chk("s5.acc_wrap", int'(phase_acc), (-k) & MASK);
            if (k > 3 && (int'(Q) > prev_q || prev_q - int'(Q) > 50)) bad_steps++;
            prev_q = int'(Q);
        end
        chk("s5.desc_steps_bad", bad_steps, 0);

        // 28.6 MHz at 112 MHz
        async_reset("s4");
        phase_inc = 20'd267750;
        rst       = 1'b1;
        xings     = 0;
        worst_pw  = 0;
        max_mag   = 0;
        prev_q    = 0;
        for (int k = 1; k <= 11200; k++) begin
            tick("s4");
            if (k >= 3) begin
                if (k > 3 && prev_q < 0 && int'(Q) >= 0) xings++;
                pw = int'(I) * int'(I) + int'(Q) * int'(Q) - M * M;
                if (pw < 0) pw = -pw;
                if (pw > worst_pw) worst_pw = pw;
                if ((int'(I) < 0 ? -int'(I) : int'(I)) > max_mag) max_mag = (int'(I) < 0 ? -int'(I) : int'(I));
                if ((int'(Q) < 0 ? -int'(Q) : int'(Q)) > max_mag) max_mag = (int'(Q) < 0 ? -int'(Q) : int'(Q));
                prev_q = int'(Q);
            end
        end
        chk_rng("s4.zero_xings", xings, 2858, 2860);
        chk_rng("s4.max_mag", max_mag, 0, M);
        chk_rng("s4.power_dev", worst_pw, 0, 33538);

        // Async reset mid-run, then the quarter-turn sequence must repeat exactly
        phase_inc = 20'd12345;
        for (int k = 0; k < 7; k++) tick("s6.pre");
        async_reset("s6");
        tick("s6.held");
        quad_seq("s6");

        // Random tuning words with occasional mid-run resets
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 4) == 0) begin
                async_reset("rnd");
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick("rnd.held");
                rst = 1'b1;
            end
            phase_inc = ($urandom_range(0, 3) == 0) ? P'($urandom_range(0, 255)) : P'($urandom_range(0, MASK));
            len = int'($urandom_range(4, 40));
            for (int k = 0; k < len; k++) tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
